// File: rtl/pipe_ctrl_seq.sv
// pipe_ctrl_seq: decodes opcode/functcode into a 14-bit control word and carries
// it through DEPTH registered stages with valid bits, stall/flush, mul/div EX
// occupancy and a halt sequencer.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal instruction traps the core).
module pipe_ctrl_seq #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [3:0]          opcode,
  input  logic [3:0]          functcode,
  input  logic                stall,
  input  logic                flush,
  output logic                in_ready,
  output logic [14*DEPTH-1:0] ctrl_out,
  output logic [DEPTH-1:0]    valid_out,
  output logic                busy,
  output logic                illegal,
  output logic                halted
);
  localparam int unsigned CW   = 14;
  localparam int unsigned CNTW = 4;
  localparam logic [CW-1:0] HALT_WORD = 14'h3FFF;
  localparam logic MULDIV_WAIT = (MULDIV_LAT > 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_MULDIV,
    ST_HALTING,
    ST_HALTED,
    ST_TRAPPED
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   ctrl_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic [CW-1:0] dec_ctrl;
  logic          dec_legal;
  logic          dec_muldiv;
  logic          accept;
  logic          issue;
  logic          bad_issue;
  logic          halt_in_ex;
  logic          halt_in_last;

  // Instruction decode table; undecodable encodings give a zero word
  always_comb begin
    dec_ctrl   = '0;
    dec_legal  = 1'b1;
    dec_muldiv = 1'b0;
    case (opcode)
      4'h0: begin
        case (functcode)
          4'h0:    dec_ctrl = 14'h37C2;
          4'h1:    dec_ctrl = 14'h37CA;
          4'h4:    begin dec_ctrl = 14'h27D3; dec_muldiv = 1'b1; end
          4'h8:    begin dec_ctrl = 14'h27DB; dec_muldiv = 1'b1; end
          4'hE:    dec_ctrl = 14'h37FB;
          4'hF:    dec_ctrl = 14'h27E2;
          default: dec_legal = 1'b0;
        endcase
      end
      4'h1:              dec_ctrl = 14'h37ED;
      4'h2:              dec_ctrl = 14'h37F5;
      4'h4, 4'h5, 4'h6:  dec_ctrl = 14'h3BC9;
      4'h8:              dec_ctrl = 14'h37C2;
      4'h9:              dec_ctrl = 14'h3C03;
      4'hA:              dec_ctrl = 14'h1703;
      4'hB:              dec_ctrl = 14'h3E03;
      4'hC:              dec_ctrl = 14'h37C2;
      4'hF:              dec_ctrl = HALT_WORD;
      default:           dec_legal = 1'b0;
    endcase
  end

  // Handshake and issue qualifiers
  assign in_ready     = (state == ST_RUN) && !stall;
  assign accept       = in_valid && in_ready;
  assign issue        = accept && !flush && dec_legal;
  assign bad_issue    = accept && !flush && !dec_legal;
  assign halt_in_ex   = vld_q[0] && (ctrl_q[0] == HALT_WORD);
  assign halt_in_last = vld_q[DEPTH-1] && (ctrl_q[DEPTH-1] == HALT_WORD);
  assign busy         = (state == ST_MULDIV);
  assign valid_out    = vld_q;

`ifdef ILLEGAL_TRAP_EN
  assign halted = (state == ST_HALTED) || ((state == ST_TRAPPED) && (vld_q == '0));
`else
  assign halted = (state == ST_HALTED);
`endif

  // Flatten stage words onto the output bus, stage 1 in the low slice
  always_comb begin
    ctrl_out = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      ctrl_out[k*CW +: CW] = ctrl_q[k];
    end
  end

  // Sequencer state, occupancy counter, pipeline stages and illegal pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      cnt     <= '0;
      vld_q   <= '0;
      illegal <= 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        ctrl_q[k] <= '0;
      end
    end else begin
      illegal <= bad_issue;

      // Stage 1: flush kills it even under stall; MULDIV holds it
      if (flush) begin
        vld_q[0]  <= 1'b0;
        ctrl_q[0] <= '0;
      end else if (!stall && (state != ST_MULDIV)) begin
        vld_q[0]  <= issue;
        ctrl_q[0] <= issue ? dec_ctrl : '0;
      end

      // Stages 2..DEPTH: a held or killed EX entry leaves a bubble behind it
      if (!stall) begin
        for (int k = 1; k < int'(DEPTH); k++) begin
          if ((k == 1) && (flush || (state == ST_MULDIV))) begin
            vld_q[k]  <= 1'b0;
            ctrl_q[k] <= '0;
          end else begin
            vld_q[k]  <= vld_q[k-1];
            ctrl_q[k] <= ctrl_q[k-1];
          end
        end
      end

      // State transitions; flush aborts anything that depends on the EX entry
      if (flush && ((state == ST_MULDIV) || ((state == ST_HALTING) && halt_in_ex))) begin
        state <= ST_RUN;
      end else if (!stall) begin
        case (state)
          ST_RUN: begin
            if (issue && dec_muldiv && MULDIV_WAIT) begin
              state <= ST_MULDIV;
              cnt   <= CNTW'(MULDIV_LAT - 1);
            end else if (issue && (dec_ctrl == HALT_WORD)) begin
              state <= ST_HALTING;
`ifdef ILLEGAL_TRAP_EN
            end else if (bad_issue) begin
              state <= ST_TRAPPED;
`endif
            end
          end
          ST_MULDIV: begin
            cnt <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) begin
              state <= ST_RUN;
            end
          end
          ST_HALTING: begin
            if (halt_in_last) begin
              state <= ST_HALTED;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
